// File: rtl/pll_clken_seq.sv
// PLL supervisor: qualifies lock, sequences the system reset, counts lock losses
// and derives NCH fractional-rate clock-enable strobes from phase accumulators.
module pll_clken_seq #(
    parameter int unsigned             NCH         = 2,
    parameter int unsigned             ACC_W       = 24,
    parameter logic [NCH*ACC_W-1:0]    INC         = {24'h800000, 24'h0147AE},
    parameter int unsigned             LOCK_CYCLES = 1024,
    parameter int unsigned             HOLD_CYCLES = 16,
    parameter int unsigned             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    output logic             sys_reset,
    output logic             ready,
    output logic [NCH-1:0]   clken,
    output logic [CNT_W-1:0] lock_lost_count
);

    localparam int unsigned MAX_CYC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         sync_q;
    logic               locked_s;
    logic               sys_reset_q;
    logic               ready_q;
    logic [NCH-1:0]     clken_q;
    logic [CNT_W-1:0]   lost_q;
    logic [ACC_W-1:0]   acc_q [NCH];
    logic [ACC_W:0]     sum_d [NCH];

    assign locked_s = sync_q[1];

    // One extra bit on each add; its MSB is the strobe for that channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sum_d[i] = {1'b0, acc_q[i]} + {1'b0, INC[i*ACC_W +: ACC_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sync_q      <= '0;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            clken_q     <= '0;
            lost_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            sync_q      <= {sync_q[0], locked};
            // Outside RUN the outputs sit in reset and the accumulators are cleared.
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            clken_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i] <= '0;
            end

            case (state_q)
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q     <= RUN;
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                        if (lost_q != '1) begin
                            lost_q <= lost_q + CNT_W'(1);
                        end
                    end else begin
                        sys_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                        for (int i = 0; i < NCH; i++) begin
                            acc_q[i]   <= sum_d[i][ACC_W-1:0];
                            clken_q[i] <= sum_d[i][ACC_W];
                        end
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase
        end
    end

    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign clken           = clken_q;
    assign lock_lost_count = lost_q;

endmodule

// File: doc/pll_clken_seq.md
Name: pll_clken_seq

Overview:
- Parametrised successor to the plain PLL wrapper; sits directly after the PLL output.
- Supervises the PLL lock signal and sequences a system reset from it.
- Generates NCH independent fractional-rate clock-enable strobes from phase accumulators, so downstream logic runs from a single PLL clock.
- Detects and counts lock-loss events; on any lock loss it re-asserts system reset and restarts the sequence.

Parameters:
- NCH, 2: number of clock-enable channels (1..8).
- ACC_W, 24: phase accumulator width in bits.
- INC, {24'h800000, 24'h0147AE}: packed NCH*ACC_W increments, channel i at bits [i*ACC_W +: ACC_W]. Output rate = f_clk*INC/2^ACC_W. Each value must be < 2^ACC_W.
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before the hold phase (>=2).
- HOLD_CYCLES, 16: extra reset-hold cycles after lock is qualified (>=1).
- CNT_W, 8: width of the lock-loss counter.

Ports:
- clk  in  1  PLL output clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- locked  in  1  raw PLL lock; asynchronous to clk.
- sys_reset  out  1  synchronous active-high reset for the rest of the design.
- ready  out  1  high while in RUN.
- clken  out  NCH  one-cycle enable strobe per channel.
- lock_lost_count  out  CNT_W  saturating count of lock drops seen in RUN.

Behaviour:
- Reset values: sys_reset=1, ready=0, clken=0, lock_lost_count=0, accumulators=0, state=WAIT_LOCK, 2-FF synchroniser=0.
- Synchroniser: locked passes through 2 flops to give locked_s. locked_s is the only lock signal used internally.
- States:
  - WAIT_LOCK -> STABLE when locked_s=1; the cycle counter clears.
  - STABLE: the counter increments each cycle that locked_s=1. When the counter reaches LOCK_CYCLES-1 with locked_s=1 -> HOLD, counter clears. If locked_s=0 -> WAIT_LOCK.
  - HOLD: counts HOLD_CYCLES cycles -> RUN. If locked_s=0 -> WAIT_LOCK.
  - RUN: stays while locked_s=1. If locked_s=0 -> WAIT_LOCK and lock_lost_count increments, saturating at all-ones.
- Registered outputs: sys_reset=1 and ready=0 in every state except RUN. sys_reset=0 and ready=1 in the same cycles the state register holds RUN.
- Latency: with locked held high from cycle 0, ready first reads 1 at cycle 2+LOCK_CYCLES+HOLD_CYCLES+1.
- Accumulators:
  - Held at 0 outside RUN.
  - In RUN, each cycle: acc_i <= (acc_i + INC_i) mod 2^ACC_W, and clken[i] <= carry out of that add.
  - clken is registered and 0 in any cycle the state is not RUN.
  - Result: the first RUN cycle has acc=0 and clken=0.
  - INC_i=0: clken[i] never pulses.
- Lock drop in RUN: the next cycle shows sys_reset=1, ready=0, clken=0, accumulators cleared.
- Glitch handling: a lock glitch shorter than one clk period may be missed by the synchroniser. This is acceptable and is not counted.
- reset asserted mid-operation: all state returns to reset values on the next edge, including lock_lost_count.
- Simultaneous reset and lock drop: reset wins; the counter is not incremented.
- Arithmetic: the accumulator add is ACC_W+1 bits wide and the MSB is the carry. No rounding; the long-run average rate is exact.

Test Plan:
- Lock sequencing: LOCK_CYCLES=8, HOLD_CYCLES=4, locked=1 from cycle 0 -> sys_reset=1 through cycle 14; ready=1 and sys_reset=0 from cycle 15.
- Half-rate channel: INC0=24'h800000 -> clken[0] pattern in RUN is 0,0,1,0,1,... (period 2, first pulse on the 3rd RUN cycle). INC1=24'h0 -> clken[1] stays 0.
- Fractional channel: INC=24'h0147AE over 2^16 RUN cycles -> clken pulse count = floor(65536*0x0147AE/2^24) = 327.
- Lock loss in RUN: drop locked for 5 cycles -> ready falls 3 cycles after the drop, lock_lost_count=1, clken=0. Re-lock -> full LOCK_CYCLES+HOLD_CYCLES sequence repeats.
- Lock drop during STABLE: at count 5 of 8 -> return to WAIT_LOCK, lock_lost_count unchanged, counter restarts from 0 on re-lock.
- Counter saturation and reset: CNT_W=2, 5 lock losses in RUN -> lock_lost_count=3. Then assert reset for 1 cycle -> count=0, sys_reset=1, ready=0.
